hsk_rx_fifo: RTL and testbench
==============================

Name: hsk_rx_fifo

Overview:
- Byte buffer between the FTDI controller's RX handshake output and the command handler's RX handshake input.
- Decouples FTDI read bursts from command-handler processing latency.
- Throttles the FTDI controller through its rx-enable input when nearly full.
- Both sides use the 4-phase req/ack handshake already used between those two blocks.

Parameters:
DATA_W, 8, byte width of the data path
DEPTH_LOG2, 4, log2 of storage depth (DEPTH = 16 entries)
AFULL_LEVEL, 12, fill level at or above which out_rx_enable is deasserted

Ports:
in_clk  input  1  system clock (clk_top_main domain)
in_rst_n  input  1  asynchronous active-low reset
in_wr_data  input  DATA_W  byte from FTDI controller; stable while in_wr_req is high
in_wr_req  input  1  upstream request (4-phase)
out_wr_ack  output  1  upstream acknowledge (4-phase)
out_rd_data  output  DATA_W  byte to command handler; stable while out_rd_req is high
out_rd_req  output  1  downstream request (4-phase)
in_rd_ack  input  1  downstream acknowledge (4-phase)
out_rx_enable  output  1  high = FTDI controller may fetch more bytes
out_level  output  DEPTH_LOG2+1  current number of stored entries, 0..DEPTH

Behaviour:
- Clock and reset: single clock in_clk; reset in_rst_n is asynchronous, active-low. All peers share in_clk, so there are no input synchronisers.
- Reset values: out_wr_ack=0, out_rd_req=0, out_rd_data=0, out_rx_enable=0, out_level=0; pointers=0; both FSMs idle.
- Write FSM states: W_IDLE, W_ACK.
  - W_IDLE: if in_wr_req=1 and level<DEPTH, store in_wr_data at wr_ptr, advance wr_ptr, set out_wr_ack=1 next cycle, go to W_ACK.
  - W_IDLE with level=DEPTH: ack withheld; request stays pending; accepted on the first cycle after a pop frees a slot.
  - W_ACK: when in_wr_req=0, clear out_wr_ack and go to W_IDLE. One byte per handshake; no write occurs in W_ACK.
- Read FSM states: R_IDLE, R_REQ, R_WAIT.
  - R_IDLE: if level>0, register mem[rd_ptr] into out_rd_data, set out_rd_req=1, go to R_REQ.
  - R_REQ: when in_rd_ack=1, clear out_rd_req, advance rd_ptr (pop), go to R_WAIT.
  - R_WAIT: when in_rd_ack=0, go to R_IDLE.
- Pointer and level arithmetic:
  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH naturally.
  - level is a separate DEPTH_LOG2+1 counter: +1 on write, -1 on pop, unchanged on simultaneous write and pop.
- Latency: with the FIFO empty, a write sampled at edge N gives out_wr_ack=1 after N and out_rd_req=1 after N+1.
- Rx enable: out_rx_enable is registered, = (level_next < AFULL_LEVEL); it is 1 from the first clock after reset release.
- Full: level=DEPTH. Producer stalls via withheld ack; no data is lost or overwritten.
- Empty: level=0. out_rd_req stays low; out_rd_data holds the last value.
- Reset mid-handshake: asynchronously drops ack/req and discards all contents. A partially acked byte is lost, which is acceptable; peers restart from idle.

Optional Feature:
- Macro: HSK_RX_FIFO_WATERMARK_EN.
- Defined: adds output out_max_level [DEPTH_LOG2:0], a high-watermark register holding the maximum out_level reached since reset. Updated each cycle as max(current, level_next). Cleared only by reset.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package ftdi_pkg:
  - DATA_W default.
  - Write FSM encodings (W_IDLE=0, W_ACK=1).
  - Read FSM encodings (R_IDLE=2'd0, R_REQ=2'd1, R_WAIT=2'd2).
- Sub-module hsk_fifo_mem: DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port, no reset on storage.
- Pointers, level counter and both FSMs stay in hsk_rx_fifo.

Test Plan:
- Single byte: write 0xA5 into an empty FIFO. Required: out_wr_ack rises 1 cycle after req is sampled; out_rd_req rises 1 cycle after that with out_rd_data=0xA5; after the consumer ack, out_level=0.
- Fill: write 16 bytes 0x00..0x0F with the consumer stalled (in_rd_ack held 0).
  - out_rx_enable falls on the cycle after the 12th write.
  - The 17th request (0x10) gets no ack; out_level stays 16.
  - After one pop, 0x10 is acked within 2 cycles.
- Drain order: after the fill scenario, consume all bytes. Required: data exits as 0x00..0x10 in order, pointer wrap is exercised, out_rx_enable re-asserts when level<12.
- Simultaneous: a write and a pop sampled on the same edge at level 5. Required: out_level stays 5 and the data order is preserved.
- Reset mid-op: assert in_rst_n=0 asynchronously while out_wr_ack=1 and out_rd_req=1. Required: all outputs are 0 immediately; after release, out_level=0 and out_rx_enable=1 after one clock.
- Watermark (macro defined): push 9 bytes, drain, push 3. Required: out_max_level=9.

Source files
------------

// File: rtl/ftdi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_pkg
// Description : Shared types and defaults for the FTDI RX handshake path.
//               Holds the default byte width and the encodings of the
//               write-side and read-side handshake state machines.
// Revision    : 1.0 - initial release
// ============================================================================
package ftdi_pkg;

    // Default byte width of the FTDI data path
    localparam int c_DATA_W = 8;

    // State register widths
    localparam int c_WR_STATE_W = 1;
    localparam int c_RD_STATE_W = 2;

    // Upstream (producer-facing) handshake states
    typedef enum logic [c_WR_STATE_W-1:0] {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wr_state_t;

    // Downstream (consumer-facing) handshake states
    typedef enum logic [c_RD_STATE_W-1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2
    } rd_state_t;

endpackage : ftdi_pkg
`default_nettype wire

// File: rtl/hsk_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : hsk_fifo_mem
// Description : DEPTH x DATA_W storage array for hsk_rx_fifo. One synchronous
//               write port, one asynchronous (combinational) read port.
//               Storage is not reset; validity is tracked by the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module hsk_fifo_mem #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    // Write the incoming byte into the addressed slot
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : hsk_fifo_mem
`default_nettype wire

// File: rtl/hsk_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hsk_rx_fifo
// Description : Byte FIFO between the FTDI controller RX handshake and the
//               command handler RX handshake. Both sides use a 4-phase
//               req/ack handshake. out_rx_enable throttles the FTDI side
//               once the fill level reaches AFULL_LEVEL.
//               Optional: define HSK_RX_FIFO_WATERMARK_EN to add the
//               out_max_level high-watermark output.
// Revision    : 1.0 - initial release
// ============================================================================
module hsk_rx_fifo
    import ftdi_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic [DATA_W-1:0]     in_wr_data,
    input  logic                  in_wr_req,
    output logic                  out_wr_ack,
    output logic [DATA_W-1:0]     out_rd_data,
    output logic                  out_rd_req,
    input  logic                  in_rd_ack,
    output logic                  out_rx_enable,
    output logic [DEPTH_LOG2:0]   out_level
`ifdef HSK_RX_FIFO_WATERMARK_EN
    ,
    output logic [DEPTH_LOG2:0]   out_max_level
`endif
);

    localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_LV = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_AFULL_LV = (DEPTH_LOG2+1)'(AFULL_LEVEL);
    localparam logic [DEPTH_LOG2:0] c_LV_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    wr_state_t               r_wr_state;
    wr_state_t               w_wr_state_nxt;
    rd_state_t               r_rd_state;
    rd_state_t               w_rd_state_nxt;

    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic [DEPTH_LOG2:0]     w_level_nxt;

    logic                    r_wr_ack;
    logic                    w_wr_ack_nxt;
    logic                    r_rd_req;
    logic                    w_rd_req_nxt;
    logic [DATA_W-1:0]       r_rd_data;
    logic                    r_rx_enable;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_rd_load;
    logic [DATA_W-1:0]       w_mem_rd_data;

    hsk_fifo_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk       (in_clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd_data)
    );

    // Producer side: accept one byte per handshake while a slot is free
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_ack_nxt   = r_wr_ack;
        w_push         = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (in_wr_req && (r_level < c_DEPTH_LV)) begin
                    w_push         = 1'b1;
                    w_wr_ack_nxt   = 1'b1;
                    w_wr_state_nxt = W_ACK;
                end
            end
            W_ACK: begin
                if (!in_wr_req) begin
                    w_wr_ack_nxt   = 1'b0;
                    w_wr_state_nxt = W_IDLE;
                end
            end
        endcase
    end

    // Consumer side: present head byte, pop it when acknowledged
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_req_nxt   = r_rd_req;
        w_rd_load      = 1'b0;
        w_pop          = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (r_level != '0) begin
                    w_rd_load      = 1'b1;
                    w_rd_req_nxt   = 1'b1;
                    w_rd_state_nxt = R_REQ;
                end
            end
            R_REQ: begin
                if (in_rd_ack) begin
                    w_rd_req_nxt   = 1'b0;
                    w_pop          = 1'b1;
                    w_rd_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (!in_rd_ack) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_rd_req_nxt   = 1'b0;
                w_rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Fill level after this cycle's push/pop (simultaneous ones cancel)
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LV_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_LV_ONE;
        end
    end

    // State, pointers, level and registered handshake outputs
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_wr_state  <= W_IDLE;
            r_rd_state  <= R_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_data   <= '0;
            r_rx_enable <= 1'b0;
        end else begin
            r_wr_state  <= w_wr_state_nxt;
            r_rd_state  <= w_rd_state_nxt;
            r_wr_ack    <= w_wr_ack_nxt;
            r_rd_req    <= w_rd_req_nxt;
            r_level     <= w_level_nxt;
            r_rx_enable <= (w_level_nxt < c_AFULL_LV);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_rd_load) begin
                r_rd_data <= w_mem_rd_data;
            end
        end
    end

    assign out_wr_ack    = r_wr_ack;
    assign out_rd_req    = r_rd_req;
    assign out_rd_data   = r_rd_data;
    assign out_rx_enable = r_rx_enable;
    assign out_level     = r_level;

`ifdef HSK_RX_FIFO_WATERMARK_EN
    logic [DEPTH_LOG2:0] r_max_level;

    // Highest fill level seen since reset
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_max_level <= '0;
        end else if (w_level_nxt > r_max_level) begin
            r_max_level <= w_level_nxt;
        end
    end

    assign out_max_level = r_max_level;
`else
    // Watermark tracking is not built in this configuration.
`endif

endmodule : hsk_rx_fifo
`default_nettype wire

// File: tb/tb_hsk_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsk_rx_fifo
// Description : Directed self-checking bench for hsk_rx_fifo. Covers reset,
//               single byte latency, fill/full stall, drain order with
//               pointer wrap, simultaneous push/pop, reset mid-handshake and
//               (when HSK_RX_FIFO_WATERMARK_EN is defined) the watermark.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsk_rx_fifo;

    logic       clk;
    logic       in_rst_n;
    logic [7:0] in_wr_data;
    logic       in_wr_req;
    logic       out_wr_ack;
    logic [7:0] out_rd_data;
    logic       out_rd_req;
    logic       in_rd_ack;
    logic       out_rx_enable;
    logic [4:0] out_level;
`ifdef HSK_RX_FIFO_WATERMARK_EN
    logic [4:0] out_max_level;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hsk_rx_fifo #(
        .DATA_W      (8),
        .DEPTH_LOG2  (4),
        .AFULL_LEVEL (12)
    ) dut (
        .in_clk        (clk),
        .in_rst_n      (in_rst_n),
        .in_wr_data    (in_wr_data),
        .in_wr_req     (in_wr_req),
        .out_wr_ack    (out_wr_ack),
        .out_rd_data   (out_rd_data),
        .out_rd_req    (out_rd_req),
        .in_rd_ack     (in_rd_ack),
        .out_rx_enable (out_rx_enable),
        .out_level     (out_level)
`ifdef HSK_RX_FIFO_WATERMARK_EN
        ,
        .out_max_level (out_max_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer: one full 4-phase write handshake
    task automatic push(input logic [7:0] d);
        int k;
        in_wr_data = d;
        in_wr_req  = 1'b1;
        k = 0;
        while (out_wr_ack !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (out_wr_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL push_ack data=%h: ack=%b required 1", d, out_wr_ack);
        end
        in_wr_req = 1'b0;
        k = 0;
        while (out_wr_ack !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
    endtask

    // Consumer: one full 4-phase read handshake with data/level checks
    task automatic pop(input logic [7:0] exp_d, input int exp_lvl);
        int k;
        k = 0;
        while (out_rd_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (out_rd_req !== 1'b1 || out_rd_data !== exp_d) begin
            n_fail++;
            $display("FAIL pop_data: req=%b data=%h required req=1 data=%h",
                     out_rd_req, out_rd_data, exp_d);
        end
        in_rd_ack = 1'b1;
        tick();
        n_tests++;
        if (out_rd_req !== 1'b0 || out_level !== 5'(exp_lvl) ||
            out_rx_enable !== (exp_lvl < 12)) begin
            n_fail++;
            $display("FAIL pop_after data=%h: req=%b level=%0d rx=%b required req=0 level=%0d rx=%b",
                     exp_d, out_rd_req, out_level, out_rx_enable, exp_lvl, (exp_lvl < 12));
        end
        in_rd_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        in_rst_n   = 1'b1;
        in_wr_req  = 1'b0;
        in_wr_data = 8'h00;
        in_rd_ack  = 1'b0;
        #2 in_rst_n = 1'b0;
        #6;
        n_tests++;
        if (out_wr_ack !== 1'b0 || out_rd_req !== 1'b0 || out_rd_data !== 8'h00 ||
            out_rx_enable !== 1'b0 || out_level !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values: ack=%b req=%b data=%h rx=%b level=%0d required all 0",
                     out_wr_ack, out_rd_req, out_rd_data, out_rx_enable, out_level);
        end
        @(posedge clk);
        @(posedge clk);
        #2 in_rst_n = 1'b1;
        #1;
        n_tests++;
        if (out_rx_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_before_clock: rx=%b required 0", out_rx_enable);
        end
        tick();
        n_tests++;
        if (out_rx_enable !== 1'b1 || out_level !== 5'd0) begin
            n_fail++;
            $display("FAIL rx_after_release: rx=%b level=%0d required rx=1 level=0",
                     out_rx_enable, out_level);
        end
    endtask

    task automatic test_single();
        in_wr_data = 8'hA5;
        in_wr_req  = 1'b1;
        tick();
        n_tests++;
        if (out_wr_ack !== 1'b1 || out_rd_req !== 1'b0 || out_level !== 5'd1) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b req=%b level=%0d required ack=1 req=0 level=1",
                     out_wr_ack, out_rd_req, out_level);
        end
        in_wr_req = 1'b0;
        tick();
        n_tests++;
        if (out_rd_req !== 1'b1 || out_rd_data !== 8'hA5 || out_wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req: req=%b data=%h ack=%b required req=1 data=a5 ack=0",
                     out_rd_req, out_rd_data, out_wr_ack);
        end
        in_rd_ack = 1'b1;
        tick();
        in_rd_ack = 1'b0;
        tick();
        n_tests++;
        if (out_level !== 5'd0 || out_rd_req !== 1'b0 || out_rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_empty: level=%0d req=%b data=%h required level=0 req=0 data=a5",
                     out_level, out_rd_req, out_rd_data);
        end
    endtask

    task automatic test_fill();
        int k;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            n_tests++;
            if (out_level !== 5'(i + 1) || out_rx_enable !== ((i + 1) < 12)) begin
                n_fail++;
                $display("FAIL fill_level%0d: level=%0d rx=%b required level=%0d rx=%b",
                         i, out_level, out_rx_enable, i + 1, ((i + 1) < 12));
            end
        end
        in_wr_data = 8'h10;
        in_wr_req  = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (out_wr_ack !== 1'b0 || out_level !== 5'd16) begin
            n_fail++;
            $display("FAIL full_stall: ack=%b level=%0d required ack=0 level=16",
                     out_wr_ack, out_level);
        end
        n_tests++;
        if (out_rd_req !== 1'b1 || out_rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL full_head: req=%b data=%h required req=1 data=00",
                     out_rd_req, out_rd_data);
        end
        in_rd_ack = 1'b1;
        tick();
        in_rd_ack = 1'b0;
        k = 0;
        while (out_wr_ack !== 1'b1 && k < 2) begin
            tick();
            k++;
        end
        n_tests++;
        if (out_wr_ack !== 1'b1 || out_level !== 5'd16) begin
            n_fail++;
            $display("FAIL full_resume: ack=%b level=%0d required ack=1 level=16",
                     out_wr_ack, out_level);
        end
        in_wr_req = 1'b0;
        tick();
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            pop(8'(i), 16 - i);
        end
        repeat (2) tick();
        n_tests++;
        if (out_rd_req !== 1'b0 || out_rd_data !== 8'h10 || out_level !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_empty: req=%b data=%h level=%0d required req=0 data=10 level=0",
                     out_rd_req, out_rd_data, out_level);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            push(8'h20 + 8'(i));
        end
        n_tests++;
        if (out_level !== 5'd5 || out_rd_req !== 1'b1 || out_rd_data !== 8'h20) begin
            n_fail++;
            $display("FAIL simul_pre: level=%0d req=%b data=%h required level=5 req=1 data=20",
                     out_level, out_rd_req, out_rd_data);
        end
        in_wr_data = 8'h25;
        in_wr_req  = 1'b1;
        in_rd_ack  = 1'b1;
        tick();
        n_tests++;
        if (out_level !== 5'd5 || out_wr_ack !== 1'b1 || out_rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_level: level=%0d ack=%b req=%b required level=5 ack=1 req=0",
                     out_level, out_wr_ack, out_rd_req);
        end
        in_wr_req = 1'b0;
        in_rd_ack = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            pop(8'h20 + 8'(i), 5 - i);
        end
    endtask

    task automatic test_reset_mid();
        in_wr_data = 8'h30;
        in_wr_req  = 1'b1;
        tick();
        tick();
        n_tests++;
        if (out_wr_ack !== 1'b1 || out_rd_req !== 1'b1 || out_rd_data !== 8'h30) begin
            n_fail++;
            $display("FAIL mid_setup: ack=%b req=%b data=%h required ack=1 req=1 data=30",
                     out_wr_ack, out_rd_req, out_rd_data);
        end
        #2 in_rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_wr_ack !== 1'b0 || out_rd_req !== 1'b0 || out_rd_data !== 8'h00 ||
            out_rx_enable !== 1'b0 || out_level !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_async: ack=%b req=%b data=%h rx=%b level=%0d required all 0",
                     out_wr_ack, out_rd_req, out_rd_data, out_rx_enable, out_level);
        end
        in_wr_req = 1'b0;
        #3 in_rst_n = 1'b1;
        tick();
        n_tests++;
        if (out_level !== 5'd0 || out_rx_enable !== 1'b1 || out_rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: level=%0d rx=%b req=%b required level=0 rx=1 req=0",
                     out_level, out_rx_enable, out_rd_req);
        end
    endtask

`ifdef HSK_RX_FIFO_WATERMARK_EN
    task automatic test_watermark();
        for (int i = 0; i < 9; i++) begin
            push(8'h40 + 8'(i));
        end
        for (int i = 0; i < 9; i++) begin
            pop(8'h40 + 8'(i), 8 - i);
        end
        for (int i = 0; i < 3; i++) begin
            push(8'h50 + 8'(i));
        end
        n_tests++;
        if (out_max_level !== 5'd9) begin
            n_fail++;
            $display("FAIL watermark: max=%0d required 9", out_max_level);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_simultaneous();
        test_reset_mid();
`ifdef HSK_RX_FIFO_WATERMARK_EN
        test_watermark();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_hsk_rx_fifo
`default_nettype wire
